// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub ops plus an iterative shift-add
// multiplier (low half), with valid/ready handshakes on input and output.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [TAGW-1:0]  tag_out
);

  localparam int unsigned CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_XOR = 4'b1100;
  localparam logic [3:0] CTL_MUL = 4'b0011;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNTW-1:0]  count_q;
  logic [TAGW-1:0]  mul_tag_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic [TAGW-1:0]  tag_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_d;
  logic             accept;
  logic             retire;

  // Single-cycle datapath, evaluated on the presented operands.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (aluctl)
      CTL_AND: alu_res = op_a & op_b;
      CTL_OR:  alu_res = op_a | op_b;
      CTL_ADD: alu_res = op_a + op_b;
      CTL_SUB: alu_res = op_a + ~op_b + WIDTH'(1);
      CTL_XOR: alu_res = op_a ^ op_b;
      CTL_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // Reset gates in_ready so nothing is accepted while the unit is held in reset.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      mul_tag_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (aluctl == CTL_MUL) begin
              mcand_q     <= op_a;
              mplier_q    <= op_b;
              acc_q       <= '0;
              count_q     <= '0;
              mul_tag_q   <= tag_in;
              out_valid_q <= 1'b0;
              state_q     <= ST_MUL;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              illegal_q   <= alu_ill;
              tag_q       <= tag_in;
              out_valid_q <= 1'b1;
            end
          end else if (retire) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CNTW'(1);
          // Final iteration publishes the accumulator including this step's add.
          if (count_q == LAST_STEP) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            illegal_q   <= 1'b0;
            tag_q       <= mul_tag_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: single-cycle ops, backpressure,
// multiply latency, illegal codes and reset behaviour.
module tb_alu_exec_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAGW  = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [TAGW-1:0]  tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [TAGW-1:0]  tag_out;

  int checks;
  int failures;

  alu_exec_unit #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluctl(aluctl), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    aluctl   = ctl;
    op_a     = a;
    op_b     = b;
    tag_in   = t;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic z,
                         input logic ill, input logic [4:0] t);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_zero"}, 64'(zero), 64'(z));
    chk({tag, "_illegal"}, 64'(illegal), 64'(ill));
    chk({tag, "_tag"}, 64'(tag_out), 64'(t));
  endtask

  // Bounded wait for out_valid; an expired budget is reported as a failure.
  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(out_valid), 64'(1));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    aluctl    = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    tag_in    = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_tag", 64'(tag_out), 64'(0));
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back single-cycle ops
    drive(4'b0010, 32'd5, 32'd7, 5'd1);
    step();
    chk_out("add", 32'd12, 1'b0, 1'b0, 5'd1);
    drive(4'b0110, 32'd9, 32'd9, 5'd2);
    step();
    chk_out("sub_zero", 32'd0, 1'b1, 1'b0, 5'd2);
    drive(4'b0110, 32'd0, 32'd1, 5'd3);
    step();
    chk_out("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd3);
    drive(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd4);
    step();
    chk_out("and", 32'h0000_F000, 1'b0, 1'b0, 5'd4);
    drive(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd5);
    step();
    chk_out("or", 32'h0000_FFF0, 1'b0, 1'b0, 5'd5);
    drive(4'b1100, 32'h0000_F0F0, 32'h0000_FF00, 5'd6);
    step();
    chk_out("xor", 32'h0000_0FF0, 1'b0, 1'b0, 5'd6);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'(0));

    // Backpressure: result held, new op stalls, then retire+accept together
    out_ready = 1'b0;
    drive(4'b0010, 32'd100, 32'd23, 5'd7);
    step();
    chk_out("bp_first", 32'd123, 1'b0, 1'b0, 5'd7);
    drive(4'b0110, 32'd50, 32'd8, 5'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_result", 64'(result), 64'(123));
      chk("bp_hold_tag", 64'(tag_out), 64'(7));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    chk_out("bp_second", 32'd42, 1'b0, 1'b0, 5'd8);
    in_valid = 1'b0;
    step();
    chk("bp_drain", 64'(out_valid), 64'(0));

    // MUL with exact latency check
    drive(4'b0011, 32'h0001_0003, 32'h0000_0005, 5'd9);
    step();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      if (cyc < 32) begin
        chk("mul_busy_valid", 64'(out_valid), 64'(0));
        chk("mul_busy_ready", 64'(in_ready), 64'(0));
      end
      step();
    end
    chk_out("mul_small", 32'h0005_000F, 1'b0, 1'b0, 5'd9);

    drive(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    step();
    in_valid = 1'b0;
    wait_valid("mul_ones", 40);
    chk_out("mul_ones", 32'h0000_0001, 1'b0, 1'b0, 5'd10);

    drive(4'b0011, 32'h0000_0000, 32'h0000_1234, 5'd11);
    step();
    in_valid = 1'b0;
    wait_valid("mul_zero", 40);
    chk_out("mul_zero", 32'h0, 1'b1, 1'b0, 5'd11);

    // Illegal code, then a legal op clears the flag
    drive(4'b0111, 32'd5, 32'd3, 5'd12);
    step();
    chk_out("illegal", 32'h0, 1'b1, 1'b1, 5'd12);
    drive(4'b0010, 32'd1, 32'd1, 5'd13);
    step();
    chk_out("after_illegal", 32'd2, 1'b0, 1'b0, 5'd13);
    in_valid = 1'b0;
    step();

    // Reset on cycle 10 of a MUL abandons it
    drive(4'b0011, 32'd3, 32'd4, 5'd14);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("mulrst_valid", 64'(out_valid), 64'(0));
    chk("mulrst_in_ready", 64'(in_ready), 64'(0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("mulrst_no_result", 64'(out_valid), 64'(0));
    end
    drive(4'b0010, 32'd2, 32'd3, 5'd15);
    step();
    chk_out("post_mulrst_add", 32'd5, 1'b0, 1'b0, 5'd15);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
